// File: rtl/apb_i2c_fifo_bridge_if.sv
// apb_i2c_fifo_bridge_if: APB bus bundle for the bridge; PSLVERR exists only with `APB_I2C_PSLVERR_EN
interface apb_i2c_fifo_bridge_if #(parameter int DATA_WIDTH = 8);
  logic PSELx;
  logic PENABLE;
  logic PWRITE;
  logic [2:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic PREADY;
`ifdef APB_I2C_PSLVERR_EN
  logic PSLVERR;
  modport slave (input PSELx, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
`else
  modport slave (input PSELx, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
`endif
endinterface

// File: rtl/apb_i2c_fifo_bridge.sv
// apb_i2c_fifo_bridge: APB slave with TX/RX FIFOs, level/status regs, RX watermark irq; `APB_I2C_PSLVERR_EN adds PSLVERR
module apb_i2c_fifo_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_i2c_fifo_bridge_if.slave  apb,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_t;
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  ptr_t tx_wptr, tx_rptr, rx_wptr, rx_rptr, tx_level, rx_level, rx_wm;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_ovf, rx_unf, rx_ovf, irq_en;
  logic fire, data_wr, data_rd, status_wr, ctrl_wr, wm_wr, tx_flush, rx_flush;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_ovf_set, rx_unf_set, rx_ovf_set;
  logic [DATA_WIDTH-1:0] rd_mux;
  assign fire = apb.PSELx && apb.PENABLE;
  assign data_wr = fire && apb.PWRITE && apb.PADDR == 3'd0;
  assign data_rd = fire && !apb.PWRITE && apb.PADDR == 3'd0;
  assign status_wr = fire && apb.PWRITE && apb.PADDR == 3'd1;
  assign ctrl_wr = fire && apb.PWRITE && apb.PADDR == 3'd4;
  assign wm_wr = fire && apb.PWRITE && apb.PADDR == 3'd5;
  assign tx_flush = ctrl_wr && apb.PWDATA[0];
  assign rx_flush = ctrl_wr && apb.PWDATA[1];
  assign tx_level = tx_wptr - tx_rptr;
  assign rx_level = rx_wptr - rx_rptr;
  assign tx_empty = tx_wptr == tx_rptr;
  assign rx_empty = rx_wptr == rx_rptr;
  assign tx_full = tx_wptr[ADDR_WIDTH] != tx_rptr[ADDR_WIDTH] && tx_wptr[ADDR_WIDTH-1:0] == tx_rptr[ADDR_WIDTH-1:0];
  assign rx_full = rx_wptr[ADDR_WIDTH] != rx_rptr[ADDR_WIDTH] && rx_wptr[ADDR_WIDTH-1:0] == rx_rptr[ADDR_WIDTH-1:0];
  // Full/empty gating uses pre-edge state, so a same-cycle pop never rescues a push into a full FIFO
  assign tx_push = data_wr && !tx_full;
  assign tx_pop = tx_valid && tx_ready;
  assign rx_push = rx_valid && !rx_full;
  assign rx_pop = data_rd && !rx_empty;
  assign tx_ovf_set = data_wr && tx_full;
  assign rx_unf_set = data_rd && rx_empty;
  assign rx_ovf_set = rx_valid && rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data = tx_mem[tx_rptr[ADDR_WIDTH-1:0]];
  always_comb begin
    case (apb.PADDR)
      3'd0: rd_mux = rx_empty ? '0 : rx_mem[rx_rptr[ADDR_WIDTH-1:0]];
      3'd1: rd_mux = DATA_WIDTH'({rx_ovf, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full});
      3'd2: rd_mux = DATA_WIDTH'(tx_level);
      3'd3: rd_mux = DATA_WIDTH'(rx_level);
      3'd4: rd_mux = DATA_WIDTH'({irq_en, 2'b00});
      3'd5: rd_mux = DATA_WIDTH'(rx_wm);
      default: rd_mux = '0;
    endcase
  end
  assign apb.PRDATA = (apb.PSELx && !apb.PWRITE) ? rd_mux : '0;
  assign apb.PREADY = 1'b1;
`ifdef APB_I2C_PSLVERR_EN
  assign apb.PSLVERR = tx_ovf_set || rx_unf_set;
`endif
  // Storage has no reset: only pointers define contents
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wptr[ADDR_WIDTH-1:0]] <= apb.PWDATA;
    if (rx_push) rx_mem[rx_wptr[ADDR_WIDTH-1:0]] <= rx_data;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      rx_ovf <= 1'b0;
      irq_en <= 1'b0;
      rx_wm <= ptr_t'(1);
      irq <= 1'b0;
    end else begin
      tx_wptr <= tx_flush ? '0 : tx_wptr + ptr_t'(tx_push);
      tx_rptr <= tx_flush ? '0 : tx_rptr + ptr_t'(tx_pop);
      rx_wptr <= rx_flush ? '0 : rx_wptr + ptr_t'(rx_push);
      rx_rptr <= rx_flush ? '0 : rx_rptr + ptr_t'(rx_pop);
      tx_ovf <= tx_ovf_set || (tx_ovf && !(status_wr && apb.PWDATA[4]));
      rx_unf <= rx_unf_set || (rx_unf && !(status_wr && apb.PWDATA[5]));
      rx_ovf <= rx_ovf_set || (rx_ovf && !(status_wr && apb.PWDATA[6]));
      irq_en <= ctrl_wr ? apb.PWDATA[2] : irq_en;
      rx_wm <= wm_wr ? apb.PWDATA[ADDR_WIDTH:0] : rx_wm;
      irq <= irq_en && ((rx_wm != '0 && rx_level >= rx_wm) || tx_ovf || rx_unf || rx_ovf);
    end
  end
endmodule

// File: tb/tb_apb_i2c_fifo_bridge.sv
// tb_apb_i2c_fifo_bridge: directed scoreboard bench for apb_i2c_fifo_bridge
module tb_apb_i2c_fifo_bridge;
  logic clk, rst_n;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, irq;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp;

  apb_i2c_fifo_bridge_if #(.DATA_WIDTH(8)) apb ();

  apb_i2c_fifo_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .PCLK(clk), .PRESETn(rst_n), .apb(apb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic apb_start(input logic w, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    apb.PSELx = 1; apb.PENABLE = 0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
    @(negedge clk);
    apb.PENABLE = 1;
  endtask

  task automatic apb_end();
    @(posedge clk); #1;
    apb.PSELx = 0; apb.PENABLE = 0; apb.PWRITE = 0;
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [7:0] d);
    apb_start(1, a, d);
    apb_end();
  endtask

  task automatic apb_rd(input logic [2:0] a, input logic [7:0] e, input logic err, input string tag);
    apb_start(0, a, 8'h00);
    check(tag, apb.PRDATA, e);
`ifdef APB_I2C_PSLVERR_EN
    check({tag, "_pslverr"}, apb.PSLVERR, err);
`else
    if (err) check({tag, "_empty_read"}, apb.PRDATA, 0);
`endif
    apb_end();
  endtask

  task automatic reg_rd(input logic [2:0] a, input logic [7:0] e, input string tag);
    apb_rd(a, e, 1'b0, tag);
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] e;
    logic empty;
    empty = rx_q.size() == 0;
    e = 8'h00;
    if (!empty) e = rx_q.pop_front();
    apb_rd(3'd0, e, empty, tag);
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic full;
    full = tx_q.size() == 8;
    apb_start(1, 3'd0, d);
`ifdef APB_I2C_PSLVERR_EN
    check("pslverr_wr", apb.PSLVERR, full);
`endif
    apb_end();
    if (!full) tx_q.push_back(d);
  endtask

  task automatic rx_in(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1; rx_data = d;
    if (rx_q.size() < 8) rx_q.push_back(d);
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) begin
      @(negedge clk);
      tx_ready = 1;
      if (tx_valid) begin
        e = tx_q.pop_front();
        check({tag, "_data"}, tx_data, e);
      end
    end
    @(negedge clk);
    check({tag, "_valid_low"}, tx_valid, 0);
    check({tag, "_left"}, tx_q.size(), 0);
    tx_ready = 0;
  endtask

  initial begin
    rst_n = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    apb.PSELx = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_irq", irq, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_pready", apb.PREADY, 1);
    check("rst_prdata", apb.PRDATA, 0);
    reg_rd(3'd1, 8'h0A, "rst_status");
    reg_rd(3'd2, 8'h00, "rst_tx_level");
    reg_rd(3'd3, 8'h00, "rst_rx_level");
    reg_rd(3'd4, 8'h00, "rst_ctrl");
    reg_rd(3'd5, 8'h01, "rst_rx_wm");
    reg_rd(3'd6, 8'h00, "reg6_zero");
    apb_wr(3'd7, 8'hFF);
    reg_rd(3'd4, 8'h00, "ctrl_after_w7");
    reg_rd(3'd1, 8'h0A, "status_after_w7");
    apb_start(1, 3'd5, 8'h02);
    check("prdata_on_write", apb.PRDATA, 0);
    apb_end();
    reg_rd(3'd5, 8'h02, "rx_wm_rw");

    for (int i = 0; i < 8; i++) wr_data(8'hA1 + 8'(i));
    reg_rd(3'd2, 8'h08, "tx_level_full");
    reg_rd(3'd1, 8'h09, "status_tx_full");
    wr_data(8'hA9);
    reg_rd(3'd1, 8'h19, "status_tx_ovf");
    reg_rd(3'd2, 8'h08, "tx_level_after_ovf");
    drain("tx_drain");
    apb_wr(3'd1, 8'h10);
    reg_rd(3'd1, 8'h0A, "status_tx_ovf_clr");

    apb_wr(3'd4, 8'h04);
    apb_wr(3'd5, 8'h03);
    reg_rd(3'd4, 8'h04, "ctrl_irq_en");
    reg_rd(3'd5, 8'h03, "rx_wm_3");
    rx_in(8'h11); rx_in(8'h22); rx_in(8'h33);
    check("irq_lag", irq, 0);
    @(posedge clk); #1;
    check("irq_rise", irq, 1);
    rd_data("rx_11");
    check("irq_hold", irq, 1);
    @(posedge clk); #1;
    check("irq_fall", irq, 0);
    reg_rd(3'd3, 8'h02, "rx_level_2");
    rd_data("rx_22");
    rd_data("rx_33");
    rd_data("rx_empty_read");
    reg_rd(3'd1, 8'h2A, "status_rx_unf");
    check("irq_unf", irq, 1);
    apb_wr(3'd1, 8'h20);
    reg_rd(3'd1, 8'h0A, "status_rx_unf_clr");
    check("irq_unf_clr", irq, 0);

    for (int i = 0; i < 8; i++) wr_data(8'hB0 + 8'(i));
    apb_start(1, 3'd0, 8'hC0);
    tx_ready = 1;
    exp = tx_q.pop_front();
    check("tx_pop_during_ovf", tx_data, exp);
`ifdef APB_I2C_PSLVERR_EN
    check("pslverr_full_pop", apb.PSLVERR, 1);
`endif
    apb_end();
    tx_ready = 0;
    reg_rd(3'd2, 8'h07, "tx_level_7");
    reg_rd(3'd1, 8'h18, "status_tx_ovf2");
    drain("tx_drain2");
    apb_wr(3'd1, 8'h10);

    for (int i = 0; i < 4; i++) rx_in(8'h41 + 8'(i));
    reg_rd(3'd3, 8'h04, "rx_level_4");
    apb_start(0, 3'd0, 8'h00);
    rx_valid = 1; rx_data = 8'h45;
    exp = rx_q.pop_front();
    check("rx_rd_during_push", apb.PRDATA, exp);
    rx_q.push_back(8'h45);
    apb_end();
    rx_valid = 0;
    reg_rd(3'd3, 8'h04, "rx_level_still_4");
    repeat (4) rd_data("rx_order");

    wr_data(8'hD1); wr_data(8'hD2);
    rx_in(8'h51); rx_in(8'h52);
    apb_start(1, 3'd4, 8'h07);
    rx_valid = 1; rx_data = 8'h55;
    apb_end();
    rx_valid = 0;
    tx_q.delete(); rx_q.delete();
    check("flush_tx_valid", tx_valid, 0);
    reg_rd(3'd2, 8'h00, "flush_tx_level");
    reg_rd(3'd3, 8'h00, "flush_rx_level");
    reg_rd(3'd4, 8'h04, "ctrl_self_clear");
    reg_rd(3'd1, 8'h0A, "status_after_flush");
    rx_in(8'h66);
    rd_data("rx_after_flush");

    apb_wr(3'd5, 8'h05);
    for (int i = 0; i < 3; i++) wr_data(8'hE0 + 8'(i));
    for (int i = 0; i < 9; i++) rx_in(8'h70 + 8'(i));
    reg_rd(3'd1, 8'h44, "status_rx_ovf");
    reg_rd(3'd3, 8'h08, "rx_level_full");
    check("irq_pre_reset", irq, 1);
    @(negedge clk);
    rst_n = 0; rx_valid = 1; rx_data = 8'h99;
    @(posedge clk); #1;
    rst_n = 1; rx_valid = 0;
    tx_q.delete(); rx_q.delete();
    check("mid_rst_irq", irq, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    reg_rd(3'd1, 8'h0A, "mid_rst_status");
    reg_rd(3'd2, 8'h00, "mid_rst_tx_level");
    reg_rd(3'd3, 8'h00, "mid_rst_rx_level");
    reg_rd(3'd4, 8'h00, "mid_rst_ctrl");
    reg_rd(3'd5, 8'h01, "mid_rst_rx_wm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
